multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multicycle CPU main control FSM; sequences PC, IR, register file, ALU, memory interface and the immediate sign/zero extender.
- Decodes Opcode and Funct from the instruction register.
- Drives datapath strobes state by state.
- Stalls on a memory ready handshake.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait for MemReady before aborting the access; 0 = wait forever.
- CNT_W, 8, width of the internal wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  6  IR[31:26]; valid from DECODE onward
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory has completed the current read or write this cycle
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR load enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegWrite  out  1  register file write enable
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- MemtoReg  out  1  write-back data: 1 = MDR, 0 = ALUOut
- ExtOp  out  1  immediate extender mode: 1 = sign-extend, 0 = zero-extend
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B: 00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2
- ALUOp  out  3  000 add, 001 sub, 010 use Funct, 011 and, 100 or
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- MemErr  out  1  one-cycle pulse on memory timeout
- State  out  4  current state, for debug

Behaviour:
- States:
  - RESET = 0, FETCH = 1, DECODE = 2, MEMADDR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6
  - REX = 7, RWB = 8, BRANCH = 9, JUMP = 10, IEX = 11, IWB = 12, TRAP = 13
- Reset: while rst_n = 0, State = RESET, the wait counter is 0 and every output is 0.
  - RESET always goes to FETCH on the next clock.
  - rst_n assertion mid-instruction aborts immediately; no further strobes are issued.
- Outputs are decoded from the state register (Moore), except PCWrite in BRANCH, which equals Zero.
- Any output not listed for a state is 0.
- FETCH:
  - Drives MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 000, PCSource = 00.
  - Holds until MemReady = 1.
  - In the MemReady cycle only, drives IRWrite = 1 and PCWrite = 1, then goes to DECODE.
- DECODE:
  - Drives ALUSrcA = 0, ALUSrcB = 11, ExtOp = 1, ALUOp = 000 (branch target).
  - Latches Opcode internally; later states use the latched copy.
  - Next state by opcode:
    - 000000 -> REX
    - 100011 (lw) or 101011 (sw) -> MEMADDR
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi), 001100 (andi), 001101 (ori) -> IEX
    - any other opcode -> see Optional Feature
- MEMADDR: ALUSrcA = 1, ALUSrcB = 10, ExtOp = 1, ALUOp = 000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead = 1, IorD = 1. Holds until MemReady, then goes to MEMWB.
- MEMWB: RegWrite = 1, RegDst = 0, MemtoReg = 1. Goes to FETCH.
- MEMWR: MemWrite = 1, IorD = 1. Holds until MemReady, then goes to FETCH.
- REX: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 010. Goes to RWB.
- RWB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Goes to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 001, PCSource = 01, PCWrite = Zero. Goes to FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Goes to FETCH.
- IEX: ALUSrcA = 1, ALUSrcB = 10.
  - addi: ExtOp = 1, ALUOp = 000.
  - andi: ExtOp = 0, ALUOp = 011.
  - ori: ExtOp = 0, ALUOp = 100.
  - Goes to IWB.
- IWB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Goes to FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with MemReady = 0.
  - Clears on every state change.
  - If MEM_TIMEOUT > 0 and the count reaches MEM_TIMEOUT with MemReady still 0: MemErr = 1 for that cycle, no IRWrite/PCWrite/RegWrite is issued, next state is FETCH.
  - MemReady in the same cycle the count hits the limit: MemReady wins and there is no error.
- Latency with zero-wait memory:
  - R-type 4 cycles, addi/andi/ori 4, lw 5, sw 4, beq 3, j 3.

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined: an undefined opcode at DECODE goes to TRAP.
  - TRAP holds all strobes at 0 and stays in TRAP until rst_n is asserted.
  - State reads 13 while trapped.
- Not defined: an undefined opcode goes from DECODE straight to FETCH (NOP); TRAP is unreachable.

Test Plan:
- Reset release, MemReady = 1 -> one cycle in RESET with all outputs 0, then FETCH with MemRead = 1, IRWrite = 1, PCWrite = 1; State sequence 0, 1, 2.
- lw (Opcode = 100011), MemReady low for 3 cycles in MEMRD -> MEMRD held 4 cycles; in MEMWB, RegWrite = 1, MemtoReg = 1, RegDst = 0; total 8 cycles.
- ori (001101) then addi (001000) -> ExtOp = 0, ALUOp = 100 in IEX for ori; ExtOp = 1, ALUOp = 000 for addi.
- beq with Zero = 1, then beq with Zero = 0 -> PCWrite = 1 with PCSource = 01 in BRANCH for the first; PCWrite = 0 for the second.
- MEM_TIMEOUT = 4, MemReady stuck at 0 in MEMWR -> MemErr pulses once on the 4th wait cycle, MemWrite drops, next State = 1.
- Opcode 111111 -> with the macro, State = 13 and holds until rst_n = 0; without it, State 2 -> 1 with no RegWrite.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for multicycle_ctrl: IR fields and status in, datapath strobes out.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       MemReady;
   logic       PCWrite;
   logic       IRWrite;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       MemtoReg;
   logic       ExtOp;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUOp;
   logic [1:0] PCSource;
   logic       MemErr;
   logic [3:0] State;

   modport master (
      input  Opcode, Funct, Zero, MemReady,
      output PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
             ExtOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, MemErr, State
   );

   modport slave (
      output Opcode, Funct, Zero, MemReady,
      input  PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
             ExtOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, MemErr, State
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU main control FSM with memory-ready stalls and optional access timeout.
// Define MULTICYCLE_CTRL_TRAP_EN to send undefined opcodes to a sticky TRAP state.
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 8
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      S_RESET   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADDR = 4'd3,
      S_MEMRD   = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_REX     = 4'd7,
      S_RWB     = 4'd8,  S_BRANCH = 4'd9, S_JUMP   = 4'd10, S_IEX     = 4'd11,
      S_IWB     = 4'd12, S_TRAP  = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic             TMO_EN   = (MEM_TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [5:0]       op_reg;
   logic             mem_wait;
   logic             timeout;

   // cnt_reg holds the number of earlier idle wait cycles, so the current cycle is wait number cnt_reg+1
   assign mem_wait = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
   assign timeout  = TMO_EN && mem_wait && !bus.MemReady && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_RESET;
         cnt_reg   <= '0;
         op_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == S_DECODE)
            op_reg <= bus.Opcode;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RESET:   state_next = S_FETCH;
         S_FETCH:   state_next = bus.MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.Opcode)
               OP_RTYPE:                 state_next = S_REX;
               OP_LW, OP_SW:             state_next = S_MEMADDR;
               OP_BEQ:                   state_next = S_BRANCH;
               OP_J:                     state_next = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI: state_next = S_IEX;
`ifdef MULTICYCLE_CTRL_TRAP_EN
               default:                  state_next = S_TRAP;
`else
               default:                  state_next = S_FETCH;
`endif
            endcase
         end
         S_MEMADDR: state_next = (op_reg == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_next = bus.MemReady ? S_MEMWB : (timeout ? S_FETCH : S_MEMRD);
         S_MEMWR:   state_next = (bus.MemReady || timeout) ? S_FETCH : S_MEMWR;
         S_REX:     state_next = S_RWB;
         S_IEX:     state_next = S_IWB;
         S_TRAP:    state_next = S_TRAP;
         default:   state_next = S_FETCH;
      endcase

      // A timeout re-enters FETCH from FETCH, so it must clear the count even without a state change
      cnt_next = cnt_reg;
      if ((state_next != state_reg) || timeout)
         cnt_next = '0;
      else if (mem_wait && !bus.MemReady && (cnt_reg != '1))
         cnt_next = cnt_reg + 1'b1;
   end

   always_comb begin
      bus.PCWrite  = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.IorD     = 1'b0;
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.RegWrite = 1'b0;
      bus.RegDst   = 1'b0;
      bus.MemtoReg = 1'b0;
      bus.ExtOp    = 1'b0;
      bus.ALUSrcA  = 1'b0;
      bus.ALUSrcB  = 2'b00;
      bus.ALUOp    = 3'b000;
      bus.PCSource = 2'b00;
      case (state_reg)
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = bus.MemReady;
            bus.PCWrite = bus.MemReady;
         end
         S_DECODE: begin
            bus.ALUSrcB = 2'b11;
            bus.ExtOp   = 1'b1;
         end
         S_MEMADDR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            bus.ExtOp   = 1'b1;
         end
         S_MEMRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
         end
         S_MEMWB: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
         end
         S_REX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = 3'b010;
         end
         S_RWB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = 1'b1;
         end
         S_BRANCH: begin
            bus.ALUSrcA  = 1'b1;
            bus.ALUOp    = 3'b001;
            bus.PCSource = 2'b01;
            bus.PCWrite  = bus.Zero;
         end
         S_JUMP: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
         end
         S_IEX: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            case (op_reg)
               OP_ANDI: bus.ALUOp = 3'b011;
               OP_ORI:  bus.ALUOp = 3'b100;
               default: begin
                  bus.ExtOp = 1'b1;
                  bus.ALUOp = 3'b000;
               end
            endcase
         end
         S_IWB: bus.RegWrite = 1'b1;
         default: ;
      endcase
   end

   assign bus.MemErr = timeout;
   assign bus.State  = state_reg;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized scoreboard bench for multicycle_ctrl: an instruction-level model queues per-cycle
// expected strobes; a monitor compares them against the DUT on every falling edge.
module tb_multicycle_ctrl;
   localparam int TMO = 4;

   localparam logic [3:0] ST_RESET = 4'd0,  ST_FETCH = 4'd1,  ST_DECODE = 4'd2, ST_MEMADDR = 4'd3;
   localparam logic [3:0] ST_MEMRD = 4'd4,  ST_MEMWB = 4'd5,  ST_MEMWR = 4'd6,  ST_REX = 4'd7;
   localparam logic [3:0] ST_RWB = 4'd8,    ST_BRANCH = 4'd9, ST_JUMP = 4'd10,  ST_IEX = 4'd11;
   localparam logic [3:0] ST_IWB = 4'd12,   ST_TRAP = 4'd13;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
   localparam logic [5:0] OP_BAD = 6'b111111, OP_BNE = 6'b000101;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, irw, iord, mrd, mwr, rw, rdst, m2r, ext, asa;
      logic [1:0] asb;
      logic [2:0] aluop;
      logic [1:0] pcsrc;
      logic       err;
   } outs_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cycle;
   outs_t exp_q[$];

   multicycle_ctrl_if bus();

   multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected strobes for one cycle, straight from the per-state output table
   function automatic outs_t exp_out(input logic [3:0] st, input logic [5:0] op,
                                     input logic mr, input logic z, input logic err);
      outs_t o;
      o     = '0;
      o.st  = st;
      o.err = err;
      case (st)
         ST_FETCH:   begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
         ST_DECODE:  begin o.asb = 2'b11; o.ext = 1; end
         ST_MEMADDR: begin o.asa = 1; o.asb = 2'b10; o.ext = 1; end
         ST_MEMRD:   begin o.mrd = 1; o.iord = 1; end
         ST_MEMWB:   begin o.rw = 1; o.m2r = 1; end
         ST_MEMWR:   begin o.mwr = 1; o.iord = 1; end
         ST_REX:     begin o.asa = 1; o.aluop = 3'b010; end
         ST_RWB:     begin o.rw = 1; o.rdst = 1; end
         ST_BRANCH:  begin o.asa = 1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.pcw = z; end
         ST_JUMP:    begin o.pcw = 1; o.pcsrc = 2'b10; end
         ST_IEX: begin
            o.asa = 1;
            o.asb = 2'b10;
            if (op == OP_ANDI)     o.aluop = 3'b011;
            else if (op == OP_ORI) o.aluop = 3'b100;
            else                   o.ext = 1;
         end
         ST_IWB:     o.rw = 1;
         default:    ;
      endcase
      return o;
   endfunction

   function automatic outs_t capture();
      outs_t o;
      o = {bus.State, bus.PCWrite, bus.IRWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.RegWrite,
           bus.RegDst, bus.MemtoReg, bus.ExtOp, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
           bus.MemErr};
      return o;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock of stimulus; the expected response for that cycle goes to the scoreboard
   task automatic tick(input logic [3:0] st, input logic [5:0] op, input logic mr,
                       input logic z, input logic err, input logic drive_op);
      @(posedge clk);
      #1;
      bus.MemReady = mr;
      bus.Zero     = z;
      bus.Opcode   = drive_op ? op : 6'($urandom);
      bus.Funct    = 6'($urandom);
      exp_q.push_back(exp_out(st, op, mr, z, err));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         rst_n        = 1'b0;
         bus.MemReady = rbit();
         bus.Zero     = rbit();
         bus.Opcode   = 6'($urandom);
         exp_q.push_back(exp_out(ST_RESET, 6'd0, 1'b0, 1'b0, 1'b0));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back(exp_out(ST_RESET, 6'd0, 1'b0, 1'b0, 1'b0));
   endtask

   // Memory access that completes after w idle cycles unless the timeout hits first
   task automatic mem_phase(input logic [3:0] st, input logic [5:0] op, input int w, output bit ok);
      logic e;
      ok = 1'b1;
      for (int k = 0; k < w; k++) begin
         e = (k == TMO - 1);
         tick(st, op, 1'b0, rbit(), e, 1'b0);
         if (e) begin
            ok = 1'b0;
            return;
         end
      end
      tick(st, op, 1'b1, rbit(), 1'b0, 1'b0);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm,
                            input bit abort);
      bit ok;
      $display("instr op=%b zero=%0b fetch_wait=%0d mem_wait=%0d abort=%0b", op, z, wf, wm, abort);
      mem_phase(ST_FETCH, op, wf, ok);
      if (!ok) return;
      tick(ST_DECODE, op, rbit(), rbit(), 1'b0, 1'b1);
      case (op)
         OP_R: begin
            tick(ST_REX, op, rbit(), rbit(), 1'b0, 1'b0);
            tick(ST_RWB, op, rbit(), rbit(), 1'b0, 1'b0);
         end
         OP_LW, OP_SW: begin
            tick(ST_MEMADDR, op, rbit(), rbit(), 1'b0, 1'b0);
            if (abort) begin
               tick((op == OP_LW) ? ST_MEMRD : ST_MEMWR, op, 1'b0, rbit(), 1'b0, 1'b0);
               do_reset(2);
               return;
            end
            mem_phase((op == OP_LW) ? ST_MEMRD : ST_MEMWR, op, wm, ok);
            if (ok && op == OP_LW) tick(ST_MEMWB, op, rbit(), rbit(), 1'b0, 1'b0);
         end
         OP_BEQ:  tick(ST_BRANCH, op, rbit(), z, 1'b0, 1'b0);
         OP_J:    tick(ST_JUMP, op, rbit(), rbit(), 1'b0, 1'b0);
         OP_ADDI, OP_ANDI, OP_ORI: begin
            tick(ST_IEX, op, rbit(), rbit(), 1'b0, 1'b0);
            tick(ST_IWB, op, rbit(), rbit(), 1'b0, 1'b0);
         end
         default: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
            for (int i = 0; i < 3; i++) tick(ST_TRAP, op, rbit(), rbit(), 1'b0, 1'b0);
            do_reset(1);
`endif
         end
      endcase
   endtask

   // Monitor: every cycle with a queued expectation is one comparison
   initial begin
      outs_t e, a;
      forever begin
         @(negedge clk);
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = capture();
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle %0d strobes: state got %0d want %0d, vector got %h want %h",
                        cycle, a.st, e.st, a, e);
            end
         end
      end
   end

   initial begin
      logic [5:0] ops[10];
      int wf, wm;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_BAD, OP_BNE};
      checks       = 0;
      errors       = 0;
      cycle        = 0;
      rst_n        = 1'b0;
      bus.Opcode   = '0;
      bus.Funct    = '0;
      bus.Zero     = 1'b0;
      bus.MemReady = 1'b0;

      do_reset(3);
      run_instr(OP_R,    1'b0, 0, 0, 1'b0);
      run_instr(OP_LW,   1'b0, 0, 3, 1'b0);
      run_instr(OP_ORI,  1'b0, 0, 0, 1'b0);
      run_instr(OP_ADDI, 1'b0, 0, 0, 1'b0);
      run_instr(OP_ANDI, 1'b0, 1, 0, 1'b0);
      run_instr(OP_BEQ,  1'b1, 0, 0, 1'b0);
      run_instr(OP_BEQ,  1'b0, 0, 0, 1'b0);
      run_instr(OP_SW,   1'b0, 0, 4, 1'b0);
      run_instr(OP_SW,   1'b0, 2, 3, 1'b0);
      run_instr(OP_LW,   1'b0, 5, 0, 1'b0);
      run_instr(OP_LW,   1'b0, 3, 0, 1'b0);
      run_instr(OP_LW,   1'b0, 0, 6, 1'b0);
      run_instr(OP_BAD,  1'b0, 0, 0, 1'b0);
      run_instr(OP_J,    1'b0, 0, 0, 1'b0);
      run_instr(OP_LW,   1'b0, 0, 0, 1'b1);
      run_instr(OP_SW,   1'b0, 0, 0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 0;
         wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 1));
         run_instr(ops[$urandom_range(0, 9)], rbit(), wf, wm, $urandom_range(0, 19) == 0);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d entries left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
